// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, Gray/binary conversion and
// reset values used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int CONV_W        = 32;

  localparam logic RST_EMPTY        = 1'b1;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_UNDERFLOW    = 1'b0;

  // Work at a fixed 32-bit width; callers zero-extend and truncate to their pointer width.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = g;
    for (int i = 1; i < CONV_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty, level and underflow tracking for the
// async FIFO. Everything here lives in the rclk domain and is registered.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = FIFO_ADDRSIZE,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                clr_underflow,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_T = AE_THRESH[PW-1:0];

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          rae_q, rae_d;
  logic          runderflow_q, runderflow_d;
  logic          pop_s;
  logic [PW-1:0] wbin_s;

  assign pop_s  = rinc & ~rempty_q;
  assign wbin_s = PW'(gray2bin(CONV_W'(rq2_wptr)));

  // Next-state for pointers and flags, all derived from the post-pop binary pointer
  always_comb begin
    rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, pop_s};
    rptr_d       = PW'(bin2gray(CONV_W'(rbin_d)));
    rempty_d     = (rptr_d == rq2_wptr);
    rlevel_d     = wbin_s - rbin_d;
    rae_d        = (rlevel_d <= AE_T);
    runderflow_d = runderflow_q;
    if (rinc && rempty_q) begin
      runderflow_d = 1'b1;
    end else if (clr_underflow) begin
      runderflow_d = 1'b0;
    end else begin
      runderflow_d = runderflow_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= RST_EMPTY;
      rae_q        <= RST_ALMOST_EMPTY;
      runderflow_q <= RST_UNDERFLOW;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      rae_q        <= rae_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr         = rbin_q[ADDRSIZE-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

endmodule
